// File: rtl/exec_stage_mc.sv
// exec_stage_mc: execute stage with single-cycle ADD/SUB, a multi-cycle MUL
// that stalls upstream while it runs, and a registered result/tag output.
module exec_stage_mc #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int OP_W    = 7,
  parameter int OFF_W   = 10,
  parameter int MUL_LAT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [REG_AW-1:0] dstin,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [OFF_W-1:0]  offsetlo,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic [REG_AW-1:0] dstout,
  output logic              illegal
);

  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'('h01);
  localparam logic [OP_W-1:0] OP_MUL = OP_W'('h02);
  localparam logic [OP_W-1:0] OP_NOP = OP_W'('h3F);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    counter, counter_next;
  logic [DATA_W-1:0]   mul_a, mul_b;
  logic [REG_AW-1:0]   mul_tag;
  logic [2*DATA_W-1:0] product;
  logic                accept;
  logic                is_mul;
  logic                mul_done;
  logic                unused_bits;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mul   = (opcode == OP_MUL);
  assign product  = {{DATA_W{1'b0}}, mul_a} * {{DATA_W{1'b0}}, mul_b};

  // The offset field and the upper product half have no consumer here.
  assign unused_bits = ^{offsetlo, product[2*DATA_W-1:DATA_W]};

  // Next-state logic: a MUL accept starts the countdown, which ends the op at counter==1.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    mul_done     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_mul) begin
          state_next   = BUSY;
          counter_next = CNT_W'(MUL_LAT - 1);
        end
      end
      BUSY: begin
        counter_next = counter - CNT_W'(1);
        if (counter == CNT_W'(1)) begin
          state_next = IDLE;
          mul_done   = 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        counter_next = '0;
      end
    endcase
  end

  // State and countdown registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  // Capture MUL operands and tag at accept so upstream may change while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_tag <= '0;
    end else if (accept && is_mul) begin
      mul_a   <= src1;
      mul_b   <= src2;
      mul_tag <= dstin;
    end
  end

  // Output register: one-cycle pulses, result/tag hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      result    <= '0;
      dstout    <= '0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      if (mul_done) begin
        out_valid <= 1'b1;
        result    <= product[DATA_W-1:0];
        dstout    <= mul_tag;
      end else if (accept) begin
        case (opcode)
          OP_ADD: begin
            out_valid <= 1'b1;
            result    <= src1 + src2;
            dstout    <= dstin;
          end
          OP_SUB: begin
            out_valid <= 1'b1;
            result    <= src1 - src2;
            dstout    <= dstin;
          end
          OP_MUL, OP_NOP: begin
          end
          default: begin
            out_valid <= 1'b1;
            illegal   <= 1'b1;
            result    <= '1;
            dstout    <= dstin;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// tb_exec_stage_mc: directed bench for exec_stage_mc with a cycle-level model
// of the 32-bit/MUL_LAT=5 instance plus a 16-bit/MUL_LAT=2 instance.
module tb_exec_stage_mc;

  localparam int LAT_A = 5;

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h01;
  localparam logic [6:0] OP_MUL = 7'h02;
  localparam logic [6:0] OP_NOP = 7'h3F;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_in_valid, a_in_ready, a_out_valid, a_illegal;
  logic [6:0]  a_opcode;
  logic [4:0]  a_dst, a_dstout;
  logic [31:0] a_src1, a_src2, a_result;
  logic [9:0]  a_off;

  logic        b_in_valid, b_in_ready, b_out_valid, b_illegal;
  logic [6:0]  b_opcode;
  logic [4:0]  b_dst, b_dstout;
  logic [15:0] b_src1, b_src2, b_result;
  logic [9:0]  b_off;

  int total = 0;
  int bad   = 0;

  // Model state: expected outputs plus the edge at which the stage frees up.
  int          k = 0;
  int          next_free = 0;
  bit          seen_rst = 1'b0;
  bit          pend = 1'b0;
  int          pend_edge = 0;
  logic [31:0] pend_res = '0;
  logic [4:0]  pend_dst = '0;
  logic        m_valid = 1'b0;
  logic        m_ill = 1'b0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_dst = '0;
  logic [63:0] p;

  always #5 clk = ~clk;

  exec_stage_mc #(.DATA_W(32), .REG_AW(5), .OP_W(7), .OFF_W(10), .MUL_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .opcode(a_opcode), .dstin(a_dst), .src1(a_src1), .src2(a_src2),
    .offsetlo(a_off), .out_valid(a_out_valid), .result(a_result),
    .dstout(a_dstout), .illegal(a_illegal)
  );

  exec_stage_mc #(.DATA_W(16), .REG_AW(5), .OP_W(7), .OFF_W(10), .MUL_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .opcode(b_opcode), .dstin(b_dst), .src1(b_src1), .src2(b_src2),
    .offsetlo(b_off), .out_valid(b_out_valid), .result(b_result),
    .dstout(b_dstout), .illegal(b_illegal)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [4:0] d,
                               input logic [31:0] x, input logic [31:0] y);
    a_in_valid = v;
    a_opcode   = op;
    a_dst      = d;
    a_src1     = x;
    a_src2     = y;
    a_off      = 10'h155;
  endtask

  // Behavioural model: each accepted op is scheduled to complete at a known edge.
  always @(posedge clk) begin
    k = k + 1;
    m_valid = 1'b0;
    m_ill   = 1'b0;
    if (rst) begin
      seen_rst  = 1'b1;
      m_res     = '0;
      m_dst     = '0;
      pend      = 1'b0;
      next_free = k + 1;
    end else begin
      if (pend && k == pend_edge) begin
        m_valid = 1'b1;
        m_res   = pend_res;
        m_dst   = pend_dst;
        pend    = 1'b0;
      end
      if (a_in_valid && k >= next_free) begin
        case (a_opcode)
          OP_ADD: begin m_valid = 1'b1; m_res = a_src1 + a_src2; m_dst = a_dst; end
          OP_SUB: begin m_valid = 1'b1; m_res = a_src1 - a_src2; m_dst = a_dst; end
          OP_MUL: begin
            p         = {32'b0, a_src1} * {32'b0, a_src2};
            pend      = 1'b1;
            pend_edge = k + LAT_A - 1;
            pend_res  = p[31:0];
            pend_dst  = a_dst;
            next_free = k + LAT_A;
          end
          OP_NOP: begin end
          default: begin m_valid = 1'b1; m_ill = 1'b1; m_res = '1; m_dst = a_dst; end
        endcase
      end
    end
  end

  // Per-cycle comparison of the 32-bit instance against the model.
  always @(negedge clk) begin
    if (seen_rst) begin
      checkOutput("cyc_out_valid", 64'(a_out_valid), 64'(m_valid));
      checkOutput("cyc_in_ready",  64'(a_in_ready),  64'(k + 1 >= next_free));
      checkOutput("cyc_illegal",   64'(a_illegal),   64'(m_ill));
      checkOutput("cyc_result",    64'(a_result),    64'(m_res));
      checkOutput("cyc_dstout",    64'(a_dstout),    64'(m_dst));
    end
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    int n_ov;
    applyStimulus(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0);
    b_in_valid = 1'b0; b_opcode = OP_ADD; b_dst = '0; b_src1 = '0; b_src2 = '0; b_off = '0;

    @(negedge clk);
    checkOutput("rst_out_valid", 64'(a_out_valid), 64'd0);
    checkOutput("rst_result",    64'(a_result),    64'd0);
    checkOutput("rst_in_ready",  64'(a_in_ready),  64'd1);
    checkOutput("rst_b_ready",   64'(b_in_ready),  64'd1);
    rst = 1'b0;
    applyStimulus(1'b1, OP_ADD, 5'd3, 32'd5, 32'd7);

    @(negedge clk);
    checkOutput("add_valid",   64'(a_out_valid), 64'd1);
    checkOutput("add_result",  64'(a_result),    64'd12);
    checkOutput("add_dst",     64'(a_dstout),    64'd3);
    checkOutput("add_illegal", 64'(a_illegal),   64'd0);
    checkOutput("model_add",   64'(m_res),       64'd12);
    applyStimulus(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0);

    @(negedge clk);
    checkOutput("add_pulse_end", 64'(a_out_valid), 64'd0);
    applyStimulus(1'b1, OP_SUB, 5'd4, 32'd0, 32'd1);

    @(negedge clk);
    checkOutput("sub_wrap", 64'(a_result), 64'hFFFF_FFFF);
    applyStimulus(1'b1, OP_ADD, 5'd5, 32'hFFFF_FFFF, 32'd2);

    @(negedge clk);
    checkOutput("b2b_valid",  64'(a_out_valid), 64'd1);
    checkOutput("b2b_result", 64'(a_result),    64'd1);
    checkOutput("b2b_ready",  64'(a_in_ready),  64'd1);
    applyStimulus(1'b1, OP_MUL, 5'd9, 32'h0001_0000, 32'h0001_0003);

    @(negedge clk);
    checkOutput("mul_busy0", 64'(a_in_ready), 64'd0);
    applyStimulus(1'b1, OP_ADD, 5'd6, 32'd10, 32'd20);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checkOutput("mul_busy", 64'(a_in_ready), 64'd0);
      checkOutput("mul_novalid", 64'(a_out_valid), 64'd0);
    end

    @(negedge clk);
    checkOutput("mul_valid",  64'(a_out_valid), 64'd1);
    checkOutput("mul_result", 64'(a_result),    64'h0003_0000);
    checkOutput("mul_dst",    64'(a_dstout),    64'd9);
    checkOutput("mul_ready",  64'(a_in_ready),  64'd1);
    checkOutput("model_mul",  64'(m_res),       64'h0003_0000);

    @(negedge clk);
    checkOutput("held_add_valid",  64'(a_out_valid), 64'd1);
    checkOutput("held_add_result", 64'(a_result),    64'd30);
    checkOutput("held_add_dst",    64'(a_dstout),    64'd6);
    applyStimulus(1'b1, OP_NOP, 5'd7, 32'd1, 32'd1);

    @(negedge clk);
    checkOutput("nop_valid",  64'(a_out_valid), 64'd0);
    checkOutput("nop_result", 64'(a_result),    64'd30);
    applyStimulus(1'b1, 7'h05, 5'd8, 32'd0, 32'd0);

    @(negedge clk);
    checkOutput("ill_valid",   64'(a_out_valid), 64'd1);
    checkOutput("ill_result",  64'(a_result),    64'hFFFF_FFFF);
    checkOutput("ill_flag",    64'(a_illegal),   64'd1);
    checkOutput("ill_dst",     64'(a_dstout),    64'd8);
    applyStimulus(1'b1, OP_MUL, 5'd10, 32'd3, 32'd4);

    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0);

    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, OP_ADD, 5'd11, 32'd100, 32'd200);

    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0);
    checkOutput("abort_valid",  64'(a_out_valid), 64'd0);
    checkOutput("abort_result", 64'(a_result),    64'd0);
    checkOutput("abort_dst",    64'(a_dstout),    64'd0);
    checkOutput("abort_ready",  64'(a_in_ready),  64'd1);
    n_ov = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_out_valid) n_ov++;
    end
    checkOutput("abort_no_pulse", 64'(n_ov), 64'd0);
    applyStimulus(1'b1, OP_ADD, 5'd12, 32'd1, 32'd1);

    @(negedge clk);
    checkOutput("post_rst_add", 64'(a_result),    64'd2);
    checkOutput("post_rst_vld", 64'(a_out_valid), 64'd1);
    applyStimulus(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0);
    b_in_valid = 1'b1; b_opcode = OP_MUL; b_dst = 5'd2; b_src1 = 16'h0100; b_src2 = 16'h0101;

    @(negedge clk);
    checkOutput("b_busy",    64'(b_in_ready),  64'd0);
    checkOutput("b_novalid", 64'(b_out_valid), 64'd0);
    b_in_valid = 1'b0;

    @(negedge clk);
    checkOutput("b_valid",  64'(b_out_valid), 64'd1);
    checkOutput("b_result", 64'(b_result),    64'h0100);
    checkOutput("b_dst",    64'(b_dstout),    64'd2);
    checkOutput("b_ready",  64'(b_in_ready),  64'd1);
    checkOutput("b_illegal", 64'(b_illegal),  64'd0);

    @(negedge clk);
    checkOutput("b_pulse_end", 64'(b_out_valid), 64'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_stage_mc.md
Name: exec_stage_mc

Overview:
- Parametrised execute stage for the in-order pipeline; successor to the single-width ADD/SUB/MUL execute unit.
- Accepts one decoded operation per cycle through a valid/ready handshake.
- ADD and SUB complete in 1 cycle. MUL is multi-cycle; while it runs, the stage holds upstream by deasserting in_ready.
- The output is a registered result with its destination register tag, qualified by out_valid, and feeds the writeback stage.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, destination register tag width.
- OP_W, 7, opcode width.
- OFF_W, 10, offset field width; carried through only, unused in this stage.
- MUL_LAT, 5, MUL latency in cycles from accept to out_valid; legal range ≥2.

Ports:
- clk, in, 1, clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, upstream operation valid.
- in_ready, out, 1, stage can accept an operation this cycle.
- opcode, in, OP_W, operation select.
- dstin, in, REG_AW, destination register tag.
- src1, in, DATA_W, operand A.
- src2, in, DATA_W, operand B.
- offsetlo, in, OFF_W, offset field; ignored.
- out_valid, out, 1, one-cycle pulse: result/dstout valid.
- result, out, DATA_W, operation result.
- dstout, out, REG_AW, tag of the completed operation.
- illegal, out, 1, set with out_valid when opcode was not recognised.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: result=0, dstout=0, out_valid=0, illegal=0, state=IDLE, counter=0. in_ready=1 in the cycle after reset.
- Accept condition: in_valid & in_ready at a rising edge. opcode, dstin, src1 and src2 are captured at accept. Input changes while BUSY are ignored.
- Opcodes:
  - 0x00 ADD: src1+src2, truncated to DATA_W.
  - 0x01 SUB: src1-src2, two's complement wrap.
  - 0x02 MUL: unsigned product, low DATA_W bits.
  - 0x3F NOP: accepted; no out_valid; result/dstout hold.
  - Any other opcode: result=all ones, illegal=1, out_valid=1, latency 1.
- Single-cycle ops (ADD/SUB/illegal), accepted at edge N: out_valid=1 with result/dstout after edge N, for exactly one cycle. in_ready stays 1, so back-to-back accepts give consecutive out_valid pulses.
- MUL FSM:
  - IDLE: in_ready=1 (combinational, in_ready = state==IDLE). A MUL accept moves to BUSY, loads counter=MUL_LAT-1 and latches the operands and tag.
  - BUSY: in_ready=0. The counter decrements each cycle. At counter==1 the next edge moves to IDLE, asserts out_valid, drives result=product and dstout=latched tag.
  - Accept edge N gives out_valid after edge N+MUL_LAT-1, i.e. MUL_LAT cycles of occupancy counting the accept cycle.
  - in_ready returns to 1 in the same cycle out_valid pulses, so a new op can be accepted there.
- Timing: MUL may be pipelined internally. Only the MUL_LAT timing above is required.
- Outputs between pulses: result and dstout hold their last value. out_valid and illegal are 0 outside pulses.
- Boundaries:
  - in_valid=0: no state change.
  - Reset during BUSY aborts the MUL: no out_valid; in_ready=1 the cycle after reset.
  - Reset and in_valid asserted together: reset wins; the operation is dropped.
  - MUL_LAT=2: one BUSY cycle.
  - There is no downstream backpressure. Writeback always consumes out_valid.

Test Plan:
- Reset then ADD: src1=5, src2=7, dst=3 → next cycle out_valid=1, result=12, dstout=3, illegal=0. The following cycle out_valid=0.
- SUB wrap: src1=0, src2=1 → result=0xFFFFFFFF. Then, back-to-back, ADD 0xFFFFFFFF+2 → result=1 on the consecutive cycle. in_ready stays 1 throughout.
- MUL, MUL_LAT=5: src1=0x10000, src2=0x10003, dst=9, accepted at edge N.
  - in_ready=0 for 4 cycles.
  - out_valid after edge N+4 with result=0x00030000 (low 32 bits), dstout=9.
  - An ADD held on in_valid during the MUL is accepted in the out_valid cycle and completes the cycle after.
- Opcode 0x3F → no out_valid, result unchanged. Opcode 0x05 → out_valid=1, result=0xFFFFFFFF, illegal=1.
- Reset asserted 2 cycles into a MUL → no out_valid ever for that MUL. After reset, outputs are 0 and in_ready=1. A subsequent ADD 1+1 → 2.
- Re-run the MUL case with MUL_LAT=2 and DATA_W=16: 0x0100*0x0101 → result=0x0100 after edge N+1, one BUSY cycle.
